music_playback_controller: RTL and testbench
============================================

// Module: music_playback_controller
// PURPOSE
//  Playback sequencer for the bank of song ROMs (Internal_MusicMemory_* family).
//  Decodes play/pause/stop/next/prev pulses, drives one-hot read_en/read_rst to
//  the selected ROM, muxes its note word to the buzzer path and detects song end.
//  Sits between the UI/debounce layer and the memory bank.
// PARAMETERS
//  NUM_SONGS     4   number of ROMs in the bank (2..8)
//  DATA_WIDTH    10  note word width; matches `DATA_WIDTH
//  START_TIMEOUT 4   cycles in PLAY with no mem ready seen -> song treated as empty
// PORTS
//  clk           in  1                      system clock
//  rst_n         in  1                      asynchronous active-low reset
//  cmd_play      in  1                      1-cycle pulse: play / resume / toggle pause
//  cmd_stop      in  1                      1-cycle pulse: stop
//  cmd_next      in  1                      1-cycle pulse: next song
//  cmd_prev      in  1                      1-cycle pulse: previous song
//  mem_data      in  NUM_SONGS*DATA_WIDTH   packed ROM data_out, song k at [k*DW +: DW]
//  mem_ready     in  NUM_SONGS              ROM output_ready bits
//  mem_read_en   out NUM_SONGS              one-hot read_en to selected ROM
//  mem_read_rst  out NUM_SONGS              one-hot read_rst to selected ROM
//  note_out      out DATA_WIDTH             note word to tone generator
//  note_valid    out 1                      note_out is a live note
//  song_idx      out clog2(NUM_SONGS)       currently selected song
//  play_state    out 3                      IDLE=0 PRIME=1 PLAY=2 PAUSE=3 DONE=4
//  song_end      out 1                      1-cycle pulse on end of song
// BEHAVIOUR
//  - Reset: state IDLE, song_idx=0, all outputs 0, seen_ready=0, timeout cnt=0.
//  - All outputs registered. Command priority in one cycle: stop > next > prev > play.
//  - IDLE: outputs 0. play -> PRIME. next/prev change song_idx only.
//  - PRIME (exactly 1 cycle): mem_read_rst[song_idx]=1, read_en=0; clear seen_ready
//    and timeout cnt; -> PLAY.
//  - PLAY: mem_read_en[song_idx]=1. seen_ready set when mem_ready[song_idx]=1.
//    note_out<=mem_data[song_idx], note_valid<=mem_ready[song_idx] (1-cycle latency).
//    End: seen_ready=1 and mem_ready[song_idx]=0, or timeout cnt reaches
//    START_TIMEOUT with seen_ready=0 -> song_end=1 for 1 cycle, -> DONE.
//    play -> PAUSE.
//  - PAUSE: read_en=0 (ROM holds pointer), note_valid=0, note_out=0; seen_ready
//    and timeout cnt held. play -> PLAY (no re-prime; resumes same position).
//  - DONE: outputs 0 except song_idx. play -> PRIME (replays same song).
//  - stop in any state -> IDLE next cycle; read_en drops same edge.
//  - next/prev: song_idx +/-1 modulo NUM_SONGS (NUM_SONGS-1 -> 0, 0 -> NUM_SONGS-1).
//    From PLAY/PAUSE/PRIME -> PRIME with new index (auto-starts); IDLE/DONE stay.
//  - Only the selected ROM ever sees read_en/read_rst; others held 0.
//  - Commands arriving during PRIME other than stop/next/prev are ignored.
//  - rst_n low mid-song: async clear to reset values; ROM pointer reset by next PRIME.
// CONFIGURATION
//  AUTO_ADVANCE_EN defined: on song end (song_end still pulses) song_idx
//    increments with wrap and state -> PRIME, so bank plays continuously.
//  AUTO_ADVANCE_EN undefined: song end -> DONE, waits for play.
// TESTING (ROM models with 3-note songs, 4-cycle sample interval)
//  1 reset, play at t0 -> PRIME read_rst[0]=1 @t0+1, read_en[0]=1 @t0+2,
//    note_valid=1 with note_out=ROM0[0] one cycle after mem_ready[0] rises.
//  2 play mid-song (note 1) -> PAUSE, note_valid=0; play again -> resumes note 1,
//    not note 0; total notes out = 3.
//  3 song runs to end -> song_end single pulse, state DONE(4), read_en=0;
//    with AUTO_ADVANCE_EN: song_idx=1, PRIME, ROM1 notes follow.
//  4 prev at song_idx=0 in PLAY -> song_idx=NUM_SONGS-1, read_rst[3]=1, ROM3 plays.
//  5 stop+next+play same cycle in PLAY -> IDLE, song_idx unchanged, outputs 0.
//  6 ROM with mem_ready stuck 0 -> song_end 4 cycles into PLAY, DONE;
//    rst_n low during PLAY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/music_playback_controller.sv
`timescale 1ns/1ps
// music_playback_controller
// Playback sequencer for a bank of song ROMs. It decodes play/pause/stop/next/prev
// pulses, drives one-hot read_en/read_rst to the selected ROM, forwards that ROM's
// note word to the tone path and detects the end of the song.
// Optional build macro: AUTO_ADVANCE_EN. When it is defined, the end of a song
// moves on to the next song (with wrap) and primes it, so the bank plays
// continuously. When it is undefined, the end of a song parks the FSM in DONE.
// note_valid marks note_out as a live note. There is no back-pressure: the tone
// generator takes the word on every cycle that note_valid is high.
module music_playback_controller #(
    parameter int NUM_SONGS     = 4,
    parameter int DATA_WIDTH    = 10,
    parameter int START_TIMEOUT = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_play,
    input  logic                            cmd_stop,
    input  logic                            cmd_next,
    input  logic                            cmd_prev,
    input  logic [NUM_SONGS*DATA_WIDTH-1:0] mem_data,
    input  logic [NUM_SONGS-1:0]            mem_ready,
    output logic [NUM_SONGS-1:0]            mem_read_en,
    output logic [NUM_SONGS-1:0]            mem_read_rst,
    output logic [DATA_WIDTH-1:0]           note_out,
    output logic                            note_valid,
    output logic [$clog2(NUM_SONGS)-1:0]    song_idx,
    output logic [2:0]                      play_state,
    output logic                            song_end
);

    localparam int IDX_W = $clog2(NUM_SONGS);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state;
    logic                   seen_ready;
    logic [CNT_W-1:0]       timeout_cnt;

    logic [IDX_W-1:0]       idx_inc;
    logic [IDX_W-1:0]       idx_dec;
    logic [IDX_W-1:0]       idx_step;
    logic [DATA_WIDTH-1:0]  cur_data;
    logic                   cur_ready;
    logic                   song_done;

    // The state register itself is the debug view of the FSM.
    assign play_state = state;

    // One-hot select for the ROM bank; every other ROM stays at 0.
    function automatic logic [NUM_SONGS-1:0] sel(input logic [IDX_W-1:0] i);
        logic [NUM_SONGS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Neighbour indices with wrap, the selected ROM's data, and end-of-song detection.
    always_comb begin
        idx_inc   = (song_idx == IDX_W'(NUM_SONGS - 1)) ? '0 : song_idx + 1'b1;
        idx_dec   = (song_idx == '0) ? IDX_W'(NUM_SONGS - 1) : song_idx - 1'b1;
        idx_step  = cmd_next ? idx_inc : idx_dec;
        cur_data  = mem_data[song_idx*DATA_WIDTH +: DATA_WIDTH];
        cur_ready = mem_ready[song_idx];
        // A song ends when ready drops after it was seen, or when ready never
        // shows up within START_TIMEOUT playing cycles (empty ROM).
        song_done = !cur_ready &&
                    (seen_ready || (timeout_cnt == CNT_W'(START_TIMEOUT - 1)));
    end

    // Playback FSM; every output is registered alongside the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            song_idx     <= '0;
            mem_read_en  <= '0;
            mem_read_rst <= '0;
            note_out     <= '0;
            note_valid   <= 1'b0;
            song_end     <= 1'b0;
            seen_ready   <= 1'b0;
            timeout_cnt  <= '0;
        end else begin
            // Per-cycle outputs are low unless the branch below re-asserts them.
            mem_read_en  <= '0;
            mem_read_rst <= '0;
            note_out     <= '0;
            note_valid   <= 1'b0;
            song_end     <= 1'b0;

            if (cmd_stop) begin
                state <= S_IDLE;
            end else if (cmd_next || cmd_prev) begin
                song_idx <= idx_step;
                // While a song is active, switching tracks re-primes and auto-starts.
                if (state == S_PRIME || state == S_PLAY || state == S_PAUSE) begin
                    state        <= S_PRIME;
                    mem_read_rst <= sel(idx_step);
                end
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (cmd_play) begin
                            state        <= S_PRIME;
                            mem_read_rst <= sel(song_idx);
                        end
                    end
                    S_PRIME: begin
                        state       <= S_PLAY;
                        mem_read_en <= sel(song_idx);
                        seen_ready  <= 1'b0;
                        timeout_cnt <= '0;
                    end
                    S_PLAY: begin
                        if (song_done) begin
                            song_end <= 1'b1;
`ifdef AUTO_ADVANCE_EN
                            song_idx     <= idx_inc;
                            state        <= S_PRIME;
                            mem_read_rst <= sel(idx_inc);
`else
                            state <= S_DONE;
`endif
                        end else if (cmd_play) begin
                            // ROM keeps its pointer because read_en drops here.
                            state <= S_PAUSE;
                        end else begin
                            mem_read_en <= sel(song_idx);
                            note_out    <= cur_data;
                            note_valid  <= cur_ready;
                            if (cur_ready) begin
                                seen_ready <= 1'b1;
                            end else if (!seen_ready) begin
                                timeout_cnt <= timeout_cnt + 1'b1;
                            end
                        end
                    end
                    S_PAUSE: begin
                        // Resume without re-priming so the song continues in place.
                        if (cmd_play) begin
                            state       <= S_PLAY;
                            mem_read_en <= sel(song_idx);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_playback_controller.sv
`timescale 1ns/1ps
// Bench for music_playback_controller: ROM models with 3-note songs (ROM2 empty),
// a song-level reference model compared every cycle, a note scoreboard, and
// directed scenarios with hand-computed literal expectations.
module tb_music_playback_controller;

  localparam int NS = 4;
  localparam int DW = 10;
  localparam int START_TIMEOUT = 4;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_PLAY  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic cmd_play = 1'b0;
  logic cmd_stop = 1'b0;
  logic cmd_next = 1'b0;
  logic cmd_prev = 1'b0;
  logic [NS*DW-1:0] mem_data;
  logic [NS-1:0] mem_ready;
  logic [NS-1:0] mem_read_en;
  logic [NS-1:0] mem_read_rst;
  logic [DW-1:0] note_out;
  logic note_valid;
  logic [1:0] song_idx;
  logic [2:0] play_state;
  logic song_end;

  music_playback_controller #(
    .NUM_SONGS(NS),
    .DATA_WIDTH(DW),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_play(cmd_play),
    .cmd_stop(cmd_stop),
    .cmd_next(cmd_next),
    .cmd_prev(cmd_prev),
    .mem_data(mem_data),
    .mem_ready(mem_ready),
    .mem_read_en(mem_read_en),
    .mem_read_rst(mem_read_rst),
    .note_out(note_out),
    .note_valid(note_valid),
    .song_idx(song_idx),
    .play_state(play_state),
    .song_end(song_end)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ROM models ----------------
  // Song k note j = 100*(k+1) + j + 1; ROM2 is empty (ready never rises).
  function automatic logic [DW-1:0] note_of(input int k, input int j);
    return DW'(100 * (k + 1) + j + 1);
  endfunction

  function automatic int rom_len(input int k);
    return (k == 2) ? 0 : 3;
  endfunction

  int rom_ptr[NS] = '{default: 0};
  int rom_tick[NS] = '{default: 0};
  logic rom_rdy[NS] = '{default: 1'b0};
  logic [DW-1:0] rom_dat[NS] = '{default: '0};

  // Each note is presented for 4 read cycles; ready stays high until the song runs out.
  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (mem_read_rst[k]) begin
        rom_ptr[k] <= 0;
        rom_tick[k] <= 0;
        rom_rdy[k] <= 1'b0;
        rom_dat[k] <= '0;
      end else if (mem_read_en[k]) begin
        if (rom_ptr[k] < rom_len(k)) begin
          rom_rdy[k] <= 1'b1;
          rom_dat[k] <= note_of(k, rom_ptr[k]);
          if (rom_tick[k] == 3) begin
            rom_tick[k] <= 0;
            rom_ptr[k] <= rom_ptr[k] + 1;
          end else begin
            rom_tick[k] <= rom_tick[k] + 1;
          end
        end else begin
          rom_rdy[k] <= 1'b0;
          rom_dat[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    mem_data = '0;
    mem_ready = '0;
    for (int k = 0; k < NS; k++) begin
      mem_data[k*DW +: DW] = rom_dat[k];
      mem_ready[k] = rom_rdy[k];
    end
  end

  // ---------------- reference model ----------------
  int m_state = M_IDLE;
  int m_idx = 0;
  int m_quiet = 0;
  bit m_seen = 1'b0;
  logic [NS-1:0] x_en = '0;
  logic [NS-1:0] x_rst = '0;
  logic [DW-1:0] x_note = '0;
  logic x_valid = 1'b0;
  logic x_end = 1'b0;

  task automatic model_clear();
    m_state = M_IDLE;
    m_idx = 0;
    m_quiet = 0;
    m_seen = 1'b0;
    x_en = '0;
    x_rst = '0;
    x_note = '0;
    x_valid = 1'b0;
    x_end = 1'b0;
  endtask

  task automatic model_step();
    bit rdy;
    logic [DW-1:0] dat;
    int quiet_next;
    bit finished;
    rdy = mem_ready[m_idx];
    dat = mem_data[m_idx*DW +: DW];
    x_en = '0;
    x_rst = '0;
    x_note = '0;
    x_valid = 1'b0;
    x_end = 1'b0;
    if (cmd_stop) begin
      m_state = M_IDLE;
    end else if (cmd_next || cmd_prev) begin
      m_idx = cmd_next ? (m_idx + 1) % NS : (m_idx + NS - 1) % NS;
      if (m_state == M_PRIME || m_state == M_PLAY || m_state == M_PAUSE) begin
        m_state = M_PRIME;
        x_rst[m_idx] = 1'b1;
      end
    end else if ((m_state == M_IDLE || m_state == M_DONE) && cmd_play) begin
      m_state = M_PRIME;
      x_rst[m_idx] = 1'b1;
    end else if (m_state == M_PRIME) begin
      m_state = M_PLAY;
      m_seen = 1'b0;
      m_quiet = 0;
      x_en[m_idx] = 1'b1;
    end else if (m_state == M_PAUSE && cmd_play) begin
      m_state = M_PLAY;
      x_en[m_idx] = 1'b1;
    end else if (m_state == M_PLAY) begin
      quiet_next = m_quiet + ((!rdy && !m_seen) ? 1 : 0);
      finished = !rdy && (m_seen || quiet_next == START_TIMEOUT);
      if (finished) begin
        x_end = 1'b1;
`ifdef AUTO_ADVANCE_EN
        m_idx = (m_idx + 1) % NS;
        m_state = M_PRIME;
        x_rst[m_idx] = 1'b1;
`else
        m_state = M_DONE;
`endif
      end else if (cmd_play) begin
        m_state = M_PAUSE;
      end else begin
        m_quiet = quiet_next;
        if (rdy) m_seen = 1'b1;
        x_en[m_idx] = 1'b1;
        x_note = dat;
        x_valid = rdy;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else model_step();
  end

  // Compare every output against the model on every cycle.
  always @(negedge clk) begin
    logic [24:0] exp_vec;
    logic [24:0] act_vec;
    exp_vec = {3'(m_state), 2'(m_idx), x_en, x_rst, x_note, x_valid, x_end};
    act_vec = {play_state, song_idx, mem_read_en, mem_read_rst, note_out, note_valid, song_end};
    checks++;
    if (act_vec !== exp_vec) begin
      failures++;
      $display("FAIL cycle_compare t=%0t actual=%h expected=%h", $time, act_vec, exp_vec);
    end
  end

  // ---------------- note scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_note = '0;
  int note_cnt = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && note_valid === 1'b1 && note_out !== last_note) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_note actual=%0d expected=none t=%0t", note_out, $time);
      end else begin
        chk("note_sequence", note_out, exp_q.pop_front());
      end
      last_note = note_out;
      note_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cmd(input bit s, input bit n, input bit p, input bit pl);
    cmd_stop = s;
    cmd_next = n;
    cmd_prev = p;
    cmd_play = pl;
    @(negedge clk);
    cmd_stop = 1'b0;
    cmd_next = 1'b0;
    cmd_prev = 1'b0;
    cmd_play = 1'b0;
  endtask

  task automatic expect_song(input int k);
    last_note = '0;
    note_cnt = 0;
    exp_q.delete();
    for (int j = 0; j < rom_len(k); j++) exp_q.push_back(note_of(k, j));
  endtask

  task automatic wait_end(input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (song_end === 1'b1) begin
        cyc = i;
        break;
      end
    end
    chk("song_end_within_budget", (cyc != 0), 1);
  endtask

  task automatic wait_note(input logic [DW-1:0] v, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (note_valid === 1'b1 && note_out === v) begin
        hit = 1'b1;
        break;
      end
    end
    chk("note_reached", hit, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", play_state, 0);
    chk("rst_idx", song_idx, 0);
    chk("rst_read_en", mem_read_en, 0);
    chk("rst_read_rst", mem_read_rst, 0);
    chk("rst_note_valid", note_valid, 0);
    chk("rst_note_out", note_out, 0);
    chk("rst_song_end", song_end, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: play from reset, prime then read, note one cycle after ready
    expect_song(0);
    cmd(0, 0, 0, 1);
    chk("t1_prime_state", play_state, 1);
    chk("t1_read_rst", mem_read_rst, 4'b0001);
    chk("t1_read_en_low", mem_read_en, 0);
    @(negedge clk);
    chk("t1_play_state", play_state, 2);
    chk("t1_read_en", mem_read_en, 4'b0001);
    chk("t1_read_rst_low", mem_read_rst, 0);
    @(negedge clk);
    chk("t1_mem_ready_up", mem_ready[0], 1);
    chk("t1_valid_lag", note_valid, 0);
    @(negedge clk);
    chk("t1_note_valid", note_valid, 1);
    chk("t1_first_note", note_out, 101);

    // 2: pause on note 1, resume on note 1
    wait_note(102, 20);
    cmd(0, 0, 0, 1);
    chk("t2_pause_state", play_state, 3);
    chk("t2_pause_valid", note_valid, 0);
    chk("t2_pause_note", note_out, 0);
    chk("t2_pause_read_en", mem_read_en, 0);
    repeat (3) @(negedge clk);
    chk("t2_pause_hold", play_state, 3);
    cmd(0, 0, 0, 1);
    chk("t2_resume_state", play_state, 2);
    @(negedge clk);
    chk("t2_resume_valid", note_valid, 1);
    chk("t2_resume_note", note_out, 102);

    // 3: run to end
    wait_end(40, cyc);
    chk("t3_read_en_low", mem_read_en, 0);
    chk("t3_valid_low", note_valid, 0);
`ifdef AUTO_ADVANCE_EN
    chk("t3_auto_state", play_state, 1);
    chk("t3_auto_idx", song_idx, 1);
    chk("t3_auto_rst", mem_read_rst, 4'b0010);
    @(negedge clk);
    chk("t3_end_pulse", song_end, 0);
    cmd(1, 0, 0, 0);
    cmd(0, 0, 1, 0);
`else
    chk("t3_done_state", play_state, 4);
    @(negedge clk);
    chk("t3_end_pulse", song_end, 0);
    chk("t3_done_hold", play_state, 4);
`endif
    chk("t3_note_count", note_cnt, 3);
    chk("t3_queue_empty", exp_q.size(), 0);

    // 4: prev at index 0 while playing wraps to 3
    expect_song(3);
    cmd(0, 0, 0, 1);
    chk("t4_replay_prime", play_state, 1);
    chk("t4_replay_rst", mem_read_rst, 4'b0001);
    @(negedge clk);
    chk("t4_play_state", play_state, 2);
    cmd(0, 0, 1, 0);
    chk("t4_wrap_idx", song_idx, 3);
    chk("t4_wrap_prime", play_state, 1);
    chk("t4_wrap_rst", mem_read_rst, 4'b1000);
    wait_end(60, cyc);
`ifdef AUTO_ADVANCE_EN
    chk("t4_auto_idx", song_idx, 0);
    cmd(1, 0, 0, 0);
    cmd(0, 0, 1, 0);
`else
    chk("t4_done_state", play_state, 4);
`endif
    chk("t4_note_count", note_cnt, 3);
    chk("t4_queue_empty", exp_q.size(), 0);

    // 5: stop beats next and play in the same cycle
    expect_song(3);
    exp_q.delete();
    cmd(0, 0, 0, 1);
    @(negedge clk);
    chk("t5_play_state", play_state, 2);
    cmd(1, 1, 0, 1);
    chk("t5_idle_state", play_state, 0);
    chk("t5_idx_kept", song_idx, 3);
    chk("t5_read_en", mem_read_en, 0);
    chk("t5_read_rst", mem_read_rst, 0);
    chk("t5_valid", note_valid, 0);

    // 6: next wraps in IDLE, empty ROM times out, async reset mid-play
    cmd(0, 1, 0, 0);
    chk("t6_next_wrap_idx", song_idx, 0);
    chk("t6_next_idle", play_state, 0);
    chk("t6_next_no_rst", mem_read_rst, 0);
    cmd(0, 1, 0, 0);
    cmd(0, 1, 0, 0);
    chk("t6_idx2", song_idx, 2);
    cmd(0, 0, 0, 1);
    chk("t6_prime_rst", mem_read_rst, 4'b0100);
    @(negedge clk);
    chk("t6_read_en", mem_read_en, 4'b0100);
    wait_end(20, cyc);
    chk("t6_timeout_cycles", cyc, 4);
`ifdef AUTO_ADVANCE_EN
    chk("t6_auto_idx", song_idx, 3);
    cmd(1, 0, 0, 0);
    cmd(0, 0, 1, 0);
`else
    chk("t6_done_state", play_state, 4);
`endif
    cmd(0, 0, 0, 1);
    @(negedge clk);
    chk("t6_replay_play", play_state, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_state", play_state, 0);
    chk("t6_async_idx", song_idx, 0);
    chk("t6_async_read_en", mem_read_en, 0);
    chk("t6_async_read_rst", mem_read_rst, 0);
    chk("t6_async_valid", note_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_post_reset_state", play_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
